// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the signed-overflow rule applied once the last difference bit is known.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Overflow is only possible when the operand signs differ; it occurs if the result sign departs from the minuend's.
    function automatic logic sub_ovf(input logic sign_a, input logic sign_b, input logic msb);
        return (sign_a != sign_b) && (msb != sign_a);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell, shared with the parallel datapath.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: d = a - b, LSB first, one bit per
// clock through a single full-adder cell (a + ~b + 1).
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] d,
    output logic             borrow,
    output logic             ovf,
    output logic             done,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-2:0] d_sh_q;
    logic             sign_a_q;
    logic             sign_b_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] d_q;
    logic             borrow_q;
    logic             ovf_q;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] d_sh_d;

    full_adder u_fa (
        .a_i (a_sh_q[0]),
        .b_i (~b_sh_q[0]),
        .c_i (carry_q),
        .s_o (fa_sum),
        .c_o (fa_cout)
    );

    // The new bit enters at the MSB; after WIDTH steps the LSB has reached bit 0.
    assign d_sh_d = {fa_sum, d_sh_q};

    // FSM, operand shifters and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            d_sh_q   <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            d_q      <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_valid) begin
                        a_sh_q   <= a;
                        b_sh_q   <= b;
                        sign_a_q <= a[WIDTH-1];
                        sign_b_q <= b[WIDTH-1];
                        carry_q  <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= ST_RUN;
                    end else begin
                        state_q  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_sh_q  <= {1'b0, a_sh_q[WIDTH-1:1]};
                    b_sh_q  <= {1'b0, b_sh_q[WIDTH-1:1]};
                    d_sh_q  <= d_sh_d[WIDTH-1:1];
                    carry_q <= fa_cout;
                    if (cnt_q == LAST_BIT) begin
                        state_q  <= ST_DONE;
                        d_q      <= d_sh_d;
                        borrow_q <= ~fa_cout;
                        ovf_q    <= sub_ovf(sign_a_q, sign_b_q, fa_sum);
                    end else begin
                        cnt_q    <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign start_ready = (state_q == ST_IDLE);
    assign busy        = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign done        = (state_q == ST_DONE);
    assign d           = d_q;
    assign borrow      = borrow_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4): a scoreboard queue filled at
// accept from an integer reference model and drained on each done pulse.
module tb_serial_subtractor;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] d;
        logic         borrow;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         borrow;
    logic         ovf;
    logic         done;
    logic         busy;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    int   last_acc = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .d           (d),
        .borrow      (borrow),
        .ovf         (ovf),
        .done        (done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; record accepts into the scoreboard and check any done pulse.
    task automatic tick();
        logic         acc;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        int           sd;
        exp_t         e;
        exp_t         got;
        acc = start_valid && start_ready && !rst;
        ea  = a;
        eb  = b;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            sb.delete();
        end else if (acc) begin
            sd       = int'($signed(ea)) - int'($signed(eb));
            e.d      = W'(ea - eb);
            e.borrow = (ea < eb);
            e.ovf    = (sd > (2**(W-1) - 1)) || (sd < -(2**(W-1)));
            sb.push_back(e);
            last_acc = cyc;
        end
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("done_without_op", 32'd1, 32'd0);
            end else begin
                got = sb.pop_front();
                check("d", d, got.d);
                check("borrow", borrow, got.borrow);
                check("ovf", ovf, got.ovf);
            end
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20 && !start_ready; k++) tick();
        check("ready_timeout", start_ready, 1'b1);
    endtask

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv);
        a = av;
        b = bv;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        wait_idle();
    endtask

    initial begin
        int prev_acc;
        int done_before;
        logic [7:0] pair;

        rst = 1'b1;
        start_valid = 1'b0;
        a = '0;
        b = '0;
        tick();
        tick();
        check("rst_ready", start_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_d", d, 4'h0);
        check("rst_borrow", borrow, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        rst = 1'b0;
        tick();

        // 7 - 3 with cycle-exact latency checks
        a = 4'd7;
        b = 4'd3;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        check("e0_ready_low", start_ready, 1'b0);
        check("e0_busy", busy, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("run_ready_low", start_ready, 1'b0);
            check("done_timing", done, (k == 4) ? 1'b1 : 1'b0);
        end
        tick();
        check("e5_ready", start_ready, 1'b1);
        check("e5_done_low", done, 1'b0);
        check("e5_busy_low", busy, 1'b0);
        check("hold_d_7m3", d, 4'h4);

        run_op(4'h3, 4'h7);
        run_op(4'h8, 4'h1);
        run_op(4'h7, 4'hF);
        run_op(4'h0, 4'h0);

        // Exhaustive sweep with start_valid held high
        start_valid = 1'b1;
        prev_acc = 0;
        for (int i = 0; i < 256; i++) begin
            pair = 8'(i);
            a = pair[7:4];
            b = pair[3:0];
            for (int k = 0; k < 20 && !start_ready; k++) tick();
            tick();
            if (i > 0) check("accept_interval", last_acc - prev_acc, 32'd6);
            prev_acc = last_acc;
        end
        start_valid = 1'b0;
        wait_idle();

        // start_valid during RUN must be ignored
        a = 4'd5;
        b = 4'd2;
        start_valid = 1'b1;
        tick();
        a = 4'hF;
        b = 4'h1;
        tick();
        tick();
        start_valid = 1'b0;
        wait_idle();
        check("ignored_d", d, 4'h3);
        for (int k = 0; k < 3; k++) tick();
        check("hold_d", d, 4'h3);
        check("hold_borrow", borrow, 1'b0);

        run_op(4'h7, 4'hF);
        check("pre_rst_borrow", borrow, 1'b1);
        check("pre_rst_ovf", ovf, 1'b1);
        check("done_count", done_cnt, 32'd263);
        check("sb_empty", sb.size(), 32'd0);

        // Reset on the 2nd RUN edge, with start_valid also high
        done_before = done_cnt;
        a = 4'd6;
        b = 4'd1;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        tick();
        rst = 1'b1;
        start_valid = 1'b1;
        tick();
        check("abort_ready", start_ready, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_d", d, 4'h0);
        check("abort_borrow", borrow, 1'b0);
        check("abort_ovf", ovf, 1'b0);
        check("abort_done", done, 1'b0);
        tick();
        check("rst_wins_busy", busy, 1'b0);
        rst = 1'b0;
        start_valid = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        check("no_abort_done", done_cnt, done_before);
        check("abort_d_hold", d, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
